uart_tx_sched: RTL
==================

# uart_tx_sched

Shared UART transmit scheduler for the microcontroller's single serial TX pin. It arbitrates byte requests from up to NREQ on-chip requesters in round-robin order. It owns the bit-period counter and restarts it at each frame start so bit edges align exactly to the start bit. It then serializes the granted byte as an 8N1 frame, or 8E1 when parity is configured in.

## Interface
- NREQ, 4, number of requesters (2..8)
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); minimum 2
- i_clk  input  1  system clock
- i_rst_n  input  1  reset; asynchronous, active-low; clock i_clk
- i_req_valid  input  NREQ  per-requester byte valid
- i_req_data  input  NREQ*8  requester k's byte at bits [8k+7:8k]
- o_req_ready  output  NREQ  one-hot accept strobe; transfer when valid&&ready
- o_grant_id  output  $clog2(NREQ)  requester owning current/last frame
- o_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle
- o_tx  output  1  serial line, idle high

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: if any i_req_valid, select the first valid index searching upward from rr_ptr+1 (mod NREQ). Assert o_req_ready for that index only, combinationally, in this cycle. Latch its byte, set o_grant_id and rr_ptr to it, then go to START.
- If no valid is set, stay in IDLE with o_req_ready all zero.
- Requesters hold data stable while valid. Deasserting valid before acceptance is legal, and nothing is latched.
- o_req_ready is never asserted outside IDLE. Requests arriving mid-frame wait.
- START: o_tx=0 for CLK_DIV cycles.
- DATA: 8 bits, LSB first, CLK_DIV cycles each. A 3-bit index counts 0..7.
- PARITY: even parity (XOR of the 8 data bits) for CLK_DIV cycles.
- STOP: o_tx=1 for CLK_DIV cycles, then go to IDLE.
- Bit counter: counts 0..CLK_DIV-1 and forces to 0 on acceptance. Tick when count==CLK_DIV-1, then wrap to 0. Each state advances only on tick.
- Counter width is $clog2(CLK_DIV). There is no overflow path.
- o_tx is registered: a glitch-free line driven from a flop.

## Timing
- Reset values: o_tx=1, o_busy=0, o_req_ready=0, o_grant_id=0, FSM=IDLE, rr_ptr=NREQ-1 (requester 0 wins first), bit counter=0.
- Acceptance at cycle A: o_tx falls at A+1, and o_busy rises at A+1.
- Each bit occupies exactly CLK_DIV cycles.
- Frame length: 10*CLK_DIV cycles (11*CLK_DIV with parity). o_tx returns high at A+1+9*CLK_DIV (10*CLK_DIV with parity).
- o_busy falls when FSM re-enters IDLE, at A+1+frame length.
- Back-to-back: the next acceptance can occur in the first IDLE cycle, so the minimum frame period is frame length + 1 cycle.
- Simultaneous valid from all requesters: each is served once per NREQ frames, in index order from the pointer.
- Reset mid-frame: o_tx goes high immediately (asynchronous), the latched byte is discarded, and the requester is not re-served.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, even parity bit inserted between bit 7 and stop, 11-bit frames.
- UART_TX_PARITY_EN undefined: PARITY state and parity logic absent, 10-bit 8N1 frames.

## Structure
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constant CLK_DIV_115200 = 868;
  - constant DATA_BITS = 8.
- Sub-module uart_bit_timer: a parameterized CLK_DIV counter with a synchronous restart input and a one-cycle tick output. The bit counter is instantiated once.
- Arbiter and FSM stay in the top module.

## Test plan
- Reset, no requests: o_tx=1, o_busy=0, o_req_ready=0 for 2000 cycles.
- CLK_DIV=4, requester 1 sends 0xA5 → o_req_ready=4'b0010 for one cycle, o_grant_id=1. Line samples every 4 cycles read 0,1,0,1,0,0,1,0,1,1 (8N1). o_busy high for 40 cycles.
- All four requesters valid continuously with bytes 0x00..0x03 → grants in order 0,1,2,3,0. Frame period is exactly 41 cycles at CLK_DIV=4.
- With UART_TX_PARITY_EN, byte 0x07 → parity bit 1. Byte 0x03 → parity bit 0. Frame is 44 cycles at CLK_DIV=4.
- Requester 2 raises valid mid-frame and drops it before frame end → never accepted, o_req_ready[2] stays 0.
- Assert i_rst_n low during DATA bit 3 → o_tx=1 asynchronously. After release, the next request to requester 0 produces a clean start bit and full frame.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit, 8E1 frames).
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable when UART_TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bit period for 115200 baud from a 100 MHz system clock
    localparam int CLK_DIV_115200 = 868;

    // Data bits per frame
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request bus between the on-chip requesters and the TX scheduler.
// Requesters drive valid/data on the master side; the scheduler returns the one-hot
// ready strobe and the id of the requester owning the current frame.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*8-1:0] i_req_data;
    logic [NREQ-1:0]   o_req_ready;
    logic [IDW-1:0]    o_grant_id;

    modport master (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_grant_id
    );

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_grant_id
    );
endinterface

// File: rtl/uart_tx_sched_bit_timer.sv
// uart_bit_timer: free-running bit-period counter 0..CLK_DIV-1 with a synchronous
// restart so a frame's bit edges line up exactly with its start bit.
// o_tick is high during the last cycle of each bit period.
module uart_bit_timer #(
    parameter int CLK_DIV = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_count;

    assign o_tick = (r_count == CW'(CLK_DIV - 1));

    // Count up, wrapping on tick; restart forces the count back to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_restart || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter plus 8N1 serializer for the shared TX pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frames).
// The ready strobe is combinational in IDLE; o_tx comes straight from a flop.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = CLK_DIV_115200
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_tx_sched_if.slave   req_if,
    output logic             o_busy,
    output logic             o_tx
);
    localparam int IDW = $clog2(NREQ);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_data;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_tick;
    logic             w_accept;
    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic [NREQ-1:0]  w_ready;

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    // Round-robin search: first valid requester after the last one served
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = (int'(r_rr_ptr) + off) % NREQ;
            if (!w_found && req_if.i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = IDW'(w_idx);
            end
        end
    end

    // Next-state logic; the line value is derived from the state being entered so
    // the registered o_tx changes on the same edge as the state
    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_accept       = 1'b0;
        w_tx_next      = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept       = 1'b1;
                    w_state_next   = START;
                    w_bit_idx_next = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_data[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = ^r_data;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    // One-hot accept strobe, only ever raised while idle
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    // FSM state, bit index and the registered serial line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    // Capture the granted byte and move the round-robin pointer on acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data     <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_data     <= req_if.i_req_data[8*w_sel +: 8];
            r_grant_id <= w_sel;
            r_rr_ptr   <= w_sel;
        end
    end

    assign req_if.o_req_ready = w_ready;
    assign req_if.o_grant_id  = r_grant_id;
    assign o_busy             = (r_state != IDLE);
    assign o_tx               = r_tx;

endmodule
